// File: rtl/pwm_audio_out_if.sv
// pwm_audio_out_if
// Groups the sample input and the PWM-side outputs of pwm_audio_out.
//   data_in          : signed 16-bit mixer sample
//   data_valid_in    : one-cycle strobe qualifying data_in
//   pwm_out          : PWM audio bit stream
//   period_start_out : pulse on the first cycle of each PWM period
//   overrun_out      : pulse when an unconsumed pending sample is overwritten
// master = sample producer / output observer, slave = pwm_audio_out.
interface pwm_audio_out_if;
  logic signed [15:0] data_in;
  logic               data_valid_in;
  logic               pwm_out;
  logic               period_start_out;
  logic               overrun_out;

  modport master (
    output data_in,
    output data_valid_in,
    input  pwm_out,
    input  period_start_out,
    input  overrun_out
  );

  modport slave (
    input  data_in,
    input  data_valid_in,
    output pwm_out,
    output period_start_out,
    output overrun_out
  );
endinterface

// File: rtl/pwm_audio_out.sv
// pwm_audio_out
// Converts signed 16-bit audio samples into a fixed-period PWM bit stream.
// Samples are converted to offset binary, parked in a one-deep pending
// register and promoted to the active register on the last cycle of a
// period, so the duty value never changes mid-period.
// Ports:
//   clk_in   : system clock, rising edge
//   reset_in : asynchronous active-high reset
//   bus      : pwm_audio_out_if.slave (data_in, data_valid_in, pwm_out,
//              period_start_out, overrun_out)
// Parameter PWM_BITS (6..10): period = 2^PWM_BITS clocks.
// Optional build macro PWM_NOISE_SHAPE_EN: first-order error feedback of the
// bits dropped when reducing the 16-bit sample to PWM_BITS.
module pwm_audio_out #(
  parameter int PWM_BITS = 8
) (
  input  logic            clk_in,
  input  logic            reset_in,
  pwm_audio_out_if.slave  bus
);

  localparam int FRAC_W = 16 - PWM_BITS;
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PWM_BITS-1:0] cnt;
  logic [15:0]         pending;
  logic                pending_full;
  logic [15:0]         active;
  logic [15:0]         sample_u;
  logic                last_cycle;
  logic                xfer;
  logic [PWM_BITS-1:0] duty;

  logic pwm_p0;
  logic period_start_p0;
  logic overrun_p0;

  // Flipping the sign bit maps two's complement onto offset binary.
  assign sample_u   = $unsigned(bus.data_in) ^ 16'h8000;
  assign last_cycle = (cnt == CNT_MAX);
  assign xfer       = last_cycle && pending_full;

  // Sample capture, pending -> active promotion and period counter
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cnt          <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      active       <= 16'h8000;
      overrun_p0   <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (xfer) begin
        active <= pending;
      end
      // A strobe coinciding with a transfer refills pending, so the flag
      // stays set; otherwise a transfer empties it.
      if (bus.data_valid_in) begin
        pending      <= sample_u;
        pending_full <= 1'b1;
      end else if (xfer) begin
        pending_full <= 1'b0;
      end
      overrun_p0 <= bus.data_valid_in && pending_full && !xfer;
    end
  end

`ifdef PWM_NOISE_SHAPE_EN
  logic [FRAC_W-1:0]   err;
  logic [PWM_BITS-1:0] duty_hold;
  logic [16:0]         shaped_sum;

  function automatic logic [PWM_BITS-1:0] sat_duty(input logic [16:0] s);
    logic [PWM_BITS-1:0] d;
    if (s[16]) begin
      d = '1;
    end else begin
      d = s[15:FRAC_W];
    end
    return d;
  endfunction

  assign shaped_sum = {1'b0, active} + {{(17 - FRAC_W){1'b0}}, err};

  // The load value is used directly on the period's first cycle and held
  // for the remaining cycles, so err only advances once per period.
  assign duty = (cnt == '0) ? sat_duty(shaped_sum) : duty_hold;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      err       <= '0;
      duty_hold <= '0;
    end else if (cnt == '0) begin
      err       <= shaped_sum[FRAC_W-1:0];
      duty_hold <= sat_duty(shaped_sum);
    end
  end
`else
  function automatic logic [PWM_BITS-1:0] trunc_duty(input logic [15:0] a);
    return a[15:FRAC_W];
  endfunction

  // active only changes on the last cycle of a period, so truncating it
  // directly already gives a duty that is constant across the period.
  assign duty = trunc_duty(active);
`endif

  // Output register stage: outputs lag cnt by one clock, so the cycle
  // where cnt==0 is registered appears as the period's first output cycle.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      pwm_p0          <= 1'b0;
      period_start_p0 <= 1'b0;
    end else begin
      pwm_p0          <= (cnt < duty);
      period_start_p0 <= (cnt == '0);
    end
  end

  assign bus.pwm_out          = pwm_p0;
  assign bus.period_start_out = period_start_p0;
  assign bus.overrun_out      = overrun_p0;

endmodule
